// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32 M-extension multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;

    // The final count is used for sign fix-up, after the 32 bit steps.
    localparam logic [CNT_W-1:0] CNT_LAST = 6'd32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

endpackage

// File: rtl/muldiv_iter_datapath.sv
// One-bit-per-cycle shift-add multiplier / restoring divider on unsigned magnitudes.
// Multiply: acc:shreg holds the running 64-bit product, opnd the multiplicand.
// Divide:   acc holds the partial remainder, shreg the quotient, opnd the divisor.
module muldiv_iter_datapath #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            step,
    input  logic            load_div,
    input  logic [XLEN-1:0] load_a,
    input  logic [XLEN-1:0] load_b,
    output logic [XLEN-1:0] acc,
    output logic [XLEN-1:0] shreg
);

    logic [XLEN-1:0] opnd;
    logic            div_mode;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;

    // Candidate next values for one multiply step and one divide step.
    always_comb begin
        mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
        div_shift = {acc, shreg[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
    end

    // Operand load and per-cycle add/subtract step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            shreg    <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc      <= '0;
            div_mode <= load_div;
            shreg    <= load_div ? load_a : load_b;
            opnd     <= load_div ? load_b : load_a;
        end else if (step) begin
            if (div_mode) begin
                acc   <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                shreg <= {shreg[XLEN-2:0], ~div_diff[XLEN]};
            end else begin
                acc   <= mul_sum[XLEN:1];
                shreg <= {mul_sum[0], shreg[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencer for the iterative M-extension unit: FSM, step counter, sign fix-up
// and pipeline handshake. Define MULDIV_EARLY_OUT_EN to finish divide-by-zero,
// signed-divide overflow and zero-operand multiplies without iterating.
module muldiv_sequencer #(
    parameter int unsigned XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import muldiv_pkg::*;

    state_t            state;
    op_t               op_q;
    logic              a_neg_q, b_neg_q, div_zero_q;
    logic [XLEN-1:0]   a_raw_q;
    logic [CNT_W-1:0]  cnt;

    op_t               op_in;
    logic              a_neg, b_neg, b_zero;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              early;
    logic [XLEN-1:0]   early_res;
    logic              dp_load, dp_step;
    logic [XLEN-1:0]   dp_acc, dp_shreg;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot, rem, final_res;

    // Operand sign decode and magnitudes for the incoming request.
    always_comb begin
        op_in  = op_t'(funct3);
        a_neg  = operand_a[XLEN-1] &
                 (op_in == OP_MULH || op_in == OP_MULHSU || op_in == OP_DIV || op_in == OP_REM);
        b_neg  = operand_b[XLEN-1] & (op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM);
        a_mag  = a_neg ? -operand_a : operand_a;
        b_mag  = b_neg ? -operand_b : operand_b;
        b_zero = (operand_b == '0);
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic div_ovf;
    assign div_ovf = (op_in == OP_DIV || op_in == OP_REM) &&
                     (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
`endif

    // Detect requests whose result is known without iterating.
    always_comb begin
        early     = 1'b0;
        early_res = '0;
`ifdef MULDIV_EARLY_OUT_EN
        if (op_in[2]) begin
            if (b_zero) begin
                early     = 1'b1;
                early_res = op_in[1] ? operand_a : '1;
            end else if (div_ovf) begin
                early     = 1'b1;
                early_res = op_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end
        end else if (operand_a == '0 || b_zero) begin
            early = 1'b1;
        end
`endif
    end

    assign dp_load = (state == ST_IDLE) && start && !flush;
    assign dp_step = (state == ST_CALC) && (cnt != CNT_LAST) && !flush;

    muldiv_iter_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (dp_load),
        .step     (dp_step),
        .load_div (funct3[2]),
        .load_a   (a_mag),
        .load_b   (b_mag),
        .acc      (dp_acc),
        .shreg    (dp_shreg)
    );

    // Sign fix-up and special-case selection of the finished result.
    always_comb begin
        final_res = '0;
        prod      = {dp_acc, dp_shreg};
        prod_fix  = (a_neg_q ^ b_neg_q) ? -prod : prod;
        quot      = (a_neg_q ^ b_neg_q) ? -dp_shreg : dp_shreg;
        rem       = a_neg_q ? -dp_acc : dp_acc;
        case (op_q)
            OP_MUL:                       final_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = div_zero_q ? '1 : quot;
            default:                      final_res = div_zero_q ? a_raw_q : rem;
        endcase
    end

    // Control FSM with registered done/result; flush aborts from any state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            op_q       <= OP_MUL;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            a_raw_q    <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            result     <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q       <= op_in;
                        a_neg_q    <= a_neg;
                        b_neg_q    <= b_neg;
                        div_zero_q <= b_zero;
                        a_raw_q    <= operand_a;
                        cnt        <= '0;
                        if (early) begin
                            state  <= ST_DONE;
                            done   <= 1'b1;
                            result <= early_res;
                        end else begin
                            state  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (cnt == CNT_LAST) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        result <= final_res;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = (state != ST_IDLE);
    assign stall = reset_n & ((start & (state == ST_IDLE) & !flush) | (state == ST_CALC));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a result/latency scoreboard.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, start, flush;
    logic [2:0]  funct3;
    logic [31:0] operand_a, operand_b;
    logic        busy, stall, done;
    logic [31:0] result;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic [31:0] last_exp = 32'h0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] x, y, p;
        logic signed [31:0] sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        x   = {{32{a[31]}}, a};
        case (f3)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin y = {{32{b[31]}}, b}; p = x * y; return p[63:32]; end
            3'd2: begin y = {32'h0, b}; p = x * y; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit early;
        if (f3[2])
            early = (b == 0) ||
                    ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        else
            early = (a == 0) || (b == 0);
        return (EARLY && early) ? 0 : 33;
    endfunction

    // Called at 1 time unit after a rising edge with the DUT idle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit hold);
        int          n;
        logic [31:0] e;
        int          l;
        start     = 1'b1;
        funct3    = f3;
        operand_a = a;
        operand_b = b;
        exp_q.push_back(ref_model(f3, a, b));
        lat_q.push_back(exp_lat(f3, a, b));
        #1;
        chk("stall_start", {63'h0, stall}, 64'h1);
        tick();
        if (hold) begin
            funct3    = ~f3;
            operand_a = ~a;
            operand_b = 32'h1234_5678;
        end else begin
            start = 1'b0;
        end
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            chk("stall_calc", {63'h0, stall}, 64'h1);
            tick();
            n++;
        end
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        chk("done_seen", {63'h0, done}, 64'h1);
        if (done === 1'b1) begin
            chk("latency", 64'(n), 64'(l));
            chk("result", {32'h0, result}, {32'h0, e});
            chk("stall_done", {63'h0, stall}, 64'h0);
        end
        tick();
        start = 1'b0;
        chk("busy_after", {63'h0, busy}, 64'h0);
        chk("result_hold", {32'h0, result}, {32'h0, e});
        last_exp = e;
    endtask

    initial begin
        bit seen;
        reset_n   = 1'b0;
        start     = 1'b0;
        flush     = 1'b0;
        funct3    = 3'd0;
        operand_a = 32'h0;
        operand_b = 32'h0;
        #1;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_stall", {63'h0, stall}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_result", {32'h0, result}, 64'h0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd5, 32'd100, 32'd0, 1'b0);
        run_op(3'd7, 32'd100, 32'd0, 1'b0);
        run_op(3'd5, 32'd100, 32'd7, 1'b0);
        run_op(3'd7, 32'd100, 32'd7, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
        run_op(3'd0, 32'd0, 32'd5, 1'b0);
        for (int i = 0; i < 8; i++)
            run_op(3'($urandom_range(7)), $urandom, $urandom, 1'b0);

        // Flush at counter 10 aborts the op.
        run_op(3'd0, 32'd3, 32'd5, 1'b0);
        start     = 1'b1;
        funct3    = 3'd0;
        operand_a = 32'd12345;
        operand_b = 32'd678;
        tick();
        start = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {63'h0, busy}, 64'h0);
        chk("flush_done", {63'h0, done}, 64'h0);
        chk("flush_result", {32'h0, result}, {32'h0, last_exp});
        seen = 1'b0;
        repeat (40) begin
            if (done === 1'b1) seen = 1'b1;
            tick();
        end
        chk("flush_no_done", {63'h0, seen}, 64'h0);
        run_op(3'd0, 32'd12345, 32'd678, 1'b0);

        // Flush together with start in IDLE: no op begins.
        start = 1'b1;
        flush = 1'b1;
        #1;
        chk("flushstart_stall", {63'h0, stall}, 64'h0);
        tick();
        start = 1'b0;
        flush = 1'b0;
        chk("flushstart_busy", {63'h0, busy}, 64'h0);

        // Asynchronous reset at counter 5.
        start     = 1'b1;
        funct3    = 3'd4;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #1 reset_n = 1'b0;
        #1;
        chk("arst_busy", {63'h0, busy}, 64'h0);
        chk("arst_stall", {63'h0, stall}, 64'h0);
        chk("arst_done", {63'h0, done}, 64'h0);
        chk("arst_result", {32'h0, result}, 64'h0);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        chk("arst_no_done", {63'h0, seen}, 64'h0);
        run_op(3'd4, 32'd1000, 32'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
